pmt_scan_sched: RTL and testbench

Programmable sequencer for the PMT scan-command bus. It stores up to DEPTH timed steps, each with a PMT select, a command nibble and a hold time in ms, and plays them out in order on the same strobe/level command interface the PMT channels already consume. A real-scan request preempts any running sequence and takes the bus. It sits between the register/command decoder and the PMT channel command inputs.

---
 rtl/pmt_scan_pkg.sv | 39 +++
 rtl/pmt_scan_sched_if.sv | 39 +++
 rtl/pmt_scan_ms_timer.sv | 39 +++
 rtl/pmt_scan_sched.sv | 160 ++++++++++++++++
 tb/tb_pmt_scan_sched.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pmt_scan_pkg.sv
// Shared types and constants for the PMT scan-command sequencer.
// Holds the FSM state encoding, the step-word field layout and the default tick rate.
package pmt_scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_ISSUE   = 3'd2,
    S_HOLD    = 3'd3,
    S_RELEASE = 3'd4,
    S_REAL    = 3'd5
  } state_e;

  localparam int CMD_LSB  = 0;
  localparam int CMD_MSB  = 3;
  localparam int SEL_LSB  = 8;
  localparam int SEL_MSB  = 10;
  localparam int HOLD_LSB = 16;
  localparam int HOLD_MSB = 31;

  localparam int UNIT_MS_DEF = 100000;

  localparam logic [3:0] CMD_REAL_START = 4'b0001;

  typedef struct packed {
    logic [15:0] hold_ms;
    logic [2:0]  sel;
    logic [3:0]  cmd;
  } step_t;

  function automatic step_t step_decode(input logic [31:0] d);
    step_t s;
    s.hold_ms = d[HOLD_MSB:HOLD_LSB];
    s.sel     = d[SEL_MSB:SEL_LSB];
    s.cmd     = d[CMD_MSB:CMD_LSB];
    return s;
  endfunction

endpackage

// File: rtl/pmt_scan_sched_if.sv
// Host-side control and PMT command-bus signals of the scan sequencer.
// master drives the controls (register decoder); slave is the sequencer.
interface pmt_scan_sched_if #(
  parameter int DEPTH = 8
);
  localparam int IW = $clog2(DEPTH);

  logic          step_wr_i;
  logic [IW-1:0] step_addr_i;
  logic [31:0]   step_data_i;
  logic [IW:0]   step_num_i;
  logic          seq_loop_i;
  logic          seq_start_i;
  logic          seq_stop_i;
  logic          real_scan_flag_i;
  logic [2:0]    real_scan_sel_i;

  logic [2:0]    pmt_scan_cmd_sel_o;
  logic [3:0]    pmt_scan_cmd_o;
  logic          seq_busy_o;
  logic [IW-1:0] seq_step_o;
  logic          seq_done_o;
  logic          seq_abort_o;

  modport master (
    output step_wr_i, step_addr_i, step_data_i, step_num_i, seq_loop_i,
           seq_start_i, seq_stop_i, real_scan_flag_i, real_scan_sel_i,
    input  pmt_scan_cmd_sel_o, pmt_scan_cmd_o, seq_busy_o, seq_step_o,
           seq_done_o, seq_abort_o
  );

  modport slave (
    input  step_wr_i, step_addr_i, step_data_i, step_num_i, seq_loop_i,
           seq_start_i, seq_stop_i, real_scan_flag_i, real_scan_sel_i,
    output pmt_scan_cmd_sel_o, pmt_scan_cmd_o, seq_busy_o, seq_step_o,
           seq_done_o, seq_abort_o
  );

endinterface

// File: rtl/pmt_scan_ms_timer.sv
// Millisecond hold timer: UNIT_MS-cycle prescaler feeding a 16-bit ms counter.
// expire_o fires in the cycle whose tick brings the ms count up to max(hold,1).
module pmt_scan_ms_timer #(
  parameter int UNIT_MS = 100000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [15:0] hold_ms_i,
  output logic        expire_o
);

  localparam int UW = (UNIT_MS > 1) ? $clog2(UNIT_MS) : 1;

  logic [UW-1:0] unit_q;
  logic [15:0]   ms_q;
  logic          tick;
  logic [15:0]   hold_eff;

  assign tick     = en_i && (unit_q == UW'(UNIT_MS - 1));
  assign hold_eff = (hold_ms_i == 16'd0) ? 16'd1 : hold_ms_i;
  assign expire_o = tick && (({1'b0, ms_q} + 17'd1) == {1'b0, hold_eff});

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      unit_q <= '0;
      ms_q   <= '0;
    end else if (en_i) begin
      if (tick) begin
        unit_q <= '0;
        ms_q   <= ms_q + 16'd1;
      end else begin
        unit_q <= unit_q + UW'(1);
      end
    end
  end

endmodule

// File: rtl/pmt_scan_sched.sv
// Programmable PMT scan sequencer: plays timed steps from a small table onto the
// strobe/level command bus; a synchronized real-scan request preempts and owns the bus.
module pmt_scan_sched
  import pmt_scan_pkg::*;
#(
  parameter int UNIT_MS = UNIT_MS_DEF,
  parameter int DEPTH   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  pmt_scan_sched_if.slave   bus
);

  localparam int IW = $clog2(DEPTH);

  step_t         tbl [DEPTH];
  step_t         step_q;

  state_e        state_q, state_n;
  logic [IW-1:0] idx_q, idx_n;
  logic [3:0]    cmd_q, cmd_n;
  logic [2:0]    sel_q, sel_n;
  logic          done_q, done_n;
  logic          abort_q, abort_n;

  logic          rs_p0, rs_p1, rs_p2;
  logic          rs_rise, rs_fall;
  logic          expire;
  logic          num_ok;
  logic          seq_active;
  logic [IW:0]   idx_inc;

  // Step table and its registered read; the read address follows idx_n so the
  // slot for the upcoming step is already in step_q during LOAD.
  always_ff @(posedge clk_i) begin
    if (bus.step_wr_i && (state_q == S_IDLE))
      tbl[bus.step_addr_i] <= step_decode(bus.step_data_i);
    step_q <= tbl[idx_n];
  end

  // Real-scan level: two synchronizer flops, third flop for edge detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rs_p0 <= 1'b0;
      rs_p1 <= 1'b0;
      rs_p2 <= 1'b0;
    end else begin
      rs_p0 <= bus.real_scan_flag_i;
      rs_p1 <= rs_p0;
      rs_p2 <= rs_p1;
    end
  end

  assign rs_rise = rs_p1 & ~rs_p2;
  assign rs_fall = ~rs_p1 & rs_p2;

  // Counting starts in ISSUE so the command-high window (HOLD plus the RELEASE
  // cycle) is exactly max(hold,1)*UNIT_MS cycles.
  pmt_scan_ms_timer #(
    .UNIT_MS (UNIT_MS)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (state_q == S_LOAD),
    .en_i      ((state_q == S_ISSUE) || (state_q == S_HOLD)),
    .hold_ms_i (step_q.hold_ms),
    .expire_o  (expire)
  );

  assign num_ok     = (bus.step_num_i != '0) && (bus.step_num_i <= (IW+1)'(DEPTH));
  assign seq_active = (state_q == S_LOAD) || (state_q == S_ISSUE) || (state_q == S_HOLD);
  assign idx_inc    = (IW+1)'(idx_q) + (IW+1)'(1);

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    cmd_n   = cmd_q;
    sel_n   = 3'd0;
    done_n  = 1'b0;
    abort_n = 1'b0;

    if (rs_rise && (state_q != S_REAL)) begin
      sel_n   = bus.real_scan_sel_i;
      cmd_n   = CMD_REAL_START;
      abort_n = (state_q != S_IDLE);
      state_n = S_REAL;
    end else if (bus.seq_stop_i && seq_active) begin
      sel_n   = step_q.sel;
      cmd_n   = 4'd0;
      abort_n = 1'b1;
      state_n = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.seq_start_i && num_ok && !rs_p1) begin
            idx_n   = '0;
            state_n = S_LOAD;
          end
        end
        S_LOAD:  state_n = S_ISSUE;
        S_ISSUE: begin
          sel_n   = step_q.sel;
          cmd_n   = step_q.cmd;
          state_n = S_HOLD;
        end
        S_HOLD: begin
          if (expire) state_n = S_RELEASE;
        end
        S_RELEASE: begin
          sel_n = step_q.sel;
          cmd_n = 4'd0;
          if (idx_inc < bus.step_num_i) begin
            idx_n   = idx_inc[IW-1:0];
            state_n = S_LOAD;
          end else if (bus.seq_loop_i) begin
            idx_n   = '0;
            state_n = S_LOAD;
          end else begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end
        end
        S_REAL: begin
          if (rs_fall) begin
            sel_n   = bus.real_scan_sel_i;
            cmd_n   = 4'd0;
            state_n = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cmd_q   <= 4'd0;
      sel_q   <= 3'd0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      cmd_q   <= cmd_n;
      sel_q   <= sel_n;
      done_q  <= done_n;
      abort_q <= abort_n;
    end
  end

  assign bus.pmt_scan_cmd_sel_o = sel_q;
  assign bus.pmt_scan_cmd_o     = cmd_q;
  assign bus.seq_busy_o         = (state_q != S_IDLE);
  assign bus.seq_step_o         = idx_q;
  assign bus.seq_done_o         = done_q;
  assign bus.seq_abort_o        = abort_q;

endmodule

// File: tb/tb_pmt_scan_sched.sv
// Scoreboard bench for pmt_scan_sched: directed scenarios push timed expected bus
// events; a negedge monitor pops and compares every strobe/done/abort and the cmd level.
module tb_pmt_scan_sched;

  localparam int UNIT  = 10;
  localparam int DEPTH = 8;

  typedef struct {
    int unsigned t;
    logic [2:0]  sel;
    logic [3:0]  cmd;
    logic [2:0]  step;
    logic        busy;
    logic        done;
    logic        abort;
  } ev_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  int unsigned cyc   = 0;
  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 1'b0;
  logic [3:0]  exp_level = 4'd0;
  ev_t         sbq[$];
  ev_t         m_e;
  int unsigned e0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  pmt_scan_sched_if #(.DEPTH(DEPTH)) bus();

  pmt_scan_sched #(
    .UNIT_MS (UNIT),
    .DEPTH   (DEPTH)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  function automatic void push(int unsigned t, logic [2:0] sel, logic [3:0] cmd,
                               logic [2:0] step, logic busy, logic done, logic abort);
    ev_t e;
    e.t = t; e.sel = sel; e.cmd = cmd; e.step = step;
    e.busy = busy; e.done = done; e.abort = abort;
    sbq.push_back(e);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe/done/abort cycle is an event; other cycles hold the level
  always @(negedge clk_i) begin
    if (mon_en) begin
      checks++;
      if (bus.pmt_scan_cmd_sel_o != 3'd0 || bus.seq_done_o || bus.seq_abort_o) begin
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event t=%0d sel=%0d cmd=%0d done=%0b abort=%0b",
                   cyc, bus.pmt_scan_cmd_sel_o, bus.pmt_scan_cmd_o, bus.seq_done_o, bus.seq_abort_o);
          exp_level = bus.pmt_scan_cmd_o;
        end else begin
          m_e = sbq.pop_front();
          if ({cyc, bus.pmt_scan_cmd_sel_o, bus.pmt_scan_cmd_o, bus.seq_step_o,
               bus.seq_busy_o, bus.seq_done_o, bus.seq_abort_o} !==
              {m_e.t, m_e.sel, m_e.cmd, m_e.step, m_e.busy, m_e.done, m_e.abort}) begin
            errors++;
            $display("FAIL event: got t=%0d sel=%0d cmd=%0d step=%0d busy=%0b done=%0b abort=%0b, expected t=%0d sel=%0d cmd=%0d step=%0d busy=%0b done=%0b abort=%0b",
                     cyc, bus.pmt_scan_cmd_sel_o, bus.pmt_scan_cmd_o, bus.seq_step_o,
                     bus.seq_busy_o, bus.seq_done_o, bus.seq_abort_o,
                     m_e.t, m_e.sel, m_e.cmd, m_e.step, m_e.busy, m_e.done, m_e.abort);
          end
          exp_level = m_e.cmd;
        end
      end else if (bus.pmt_scan_cmd_o !== exp_level) begin
        errors++;
        $display("FAIL cmd_level t=%0d: got %0h expected %0h", cyc, bus.pmt_scan_cmd_o, exp_level);
      end
      if (rst_i) exp_level = 4'd0;
    end
  end

  task automatic next();
    @(posedge clk_i);
    #1;
  endtask

  task automatic step_to(input int unsigned t);
    while (cyc < t) next();
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    bus.step_wr_i   = 1'b1;
    bus.step_addr_i = addr;
    bus.step_data_i = data;
    next();
    bus.step_wr_i   = 1'b0;
  endtask

  // Returns the cycle stamp E of the edge after which start was driven
  task automatic start_seq(input logic [3:0] num, input logic loop, output int unsigned e);
    bus.step_num_i  = num;
    bus.seq_loop_i  = loop;
    bus.seq_start_i = 1'b1;
    e = cyc;
    next();
    bus.seq_start_i = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      next();
      n++;
    end
    next();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d events pending expected 0", name, sbq.size());
      sbq.delete();
    end
    check({name, "_idle"}, {31'd0, bus.seq_busy_o}, 32'd0);
  endtask

  // Three-step table, loop off: 20/10/10 cycles of cmd with 2 idle cycles between
  task automatic push_three(input int unsigned e);
    push(e + 3,  3'b001, 4'd1, 3'd0, 1'b1, 1'b0, 1'b0);
    push(e + 23, 3'b001, 4'd0, 3'd1, 1'b1, 1'b0, 1'b0);
    push(e + 25, 3'b010, 4'd2, 3'd1, 1'b1, 1'b0, 1'b0);
    push(e + 35, 3'b010, 4'd0, 3'd2, 1'b1, 1'b0, 1'b0);
    push(e + 37, 3'b100, 4'd1, 3'd2, 1'b1, 1'b0, 1'b0);
    push(e + 47, 3'b100, 4'd0, 3'd2, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.step_wr_i        = 1'b0;
    bus.step_addr_i      = '0;
    bus.step_data_i      = '0;
    bus.step_num_i       = '0;
    bus.seq_loop_i       = 1'b0;
    bus.seq_start_i      = 1'b0;
    bus.seq_stop_i       = 1'b0;
    bus.real_scan_flag_i = 1'b0;
    bus.real_scan_sel_i  = 3'b011;
    rst_i = 1'b1;
    repeat (3) next();
    rst_i = 1'b0;
    next();

    check("rst_cmd",   {28'd0, bus.pmt_scan_cmd_o},     32'd0);
    check("rst_sel",   {29'd0, bus.pmt_scan_cmd_sel_o}, 32'd0);
    check("rst_busy",  {31'd0, bus.seq_busy_o},         32'd0);
    check("rst_step",  {29'd0, bus.seq_step_o},         32'd0);
    check("rst_done",  {31'd0, bus.seq_done_o},         32'd0);
    check("rst_abort", {31'd0, bus.seq_abort_o},        32'd0);
    mon_en = 1'b1;

    wr(3'd0, 32'h0002_0101);
    wr(3'd1, 32'h0001_0202);
    wr(3'd2, 32'h0000_0401);

    // Out-of-range step counts are ignored
    start_seq(4'd0, 1'b0, e0);
    check("start_num0_busy", {31'd0, bus.seq_busy_o}, 32'd0);
    start_seq(4'd9, 1'b0, e0);
    check("start_num9_busy", {31'd0, bus.seq_busy_o}, 32'd0);

    // Plain run
    start_seq(4'd3, 1'b0, e0);
    push_three(e0);
    check("run_busy_after_start", {31'd0, bus.seq_busy_o}, 32'd1);
    check("run_step_after_start", {29'd0, bus.seq_step_o}, 32'd0);
    drain("run", 100);

    // Looping run, stopped during the second pass of step 0
    start_seq(4'd3, 1'b1, e0);
    push(e0 + 3,  3'b001, 4'd1, 3'd0, 1'b1, 1'b0, 1'b0);
    push(e0 + 23, 3'b001, 4'd0, 3'd1, 1'b1, 1'b0, 1'b0);
    push(e0 + 25, 3'b010, 4'd2, 3'd1, 1'b1, 1'b0, 1'b0);
    push(e0 + 35, 3'b010, 4'd0, 3'd2, 1'b1, 1'b0, 1'b0);
    push(e0 + 37, 3'b100, 4'd1, 3'd2, 1'b1, 1'b0, 1'b0);
    push(e0 + 47, 3'b100, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    push(e0 + 49, 3'b001, 4'd1, 3'd0, 1'b1, 1'b0, 1'b0);
    push(e0 + 56, 3'b001, 4'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    step_to(e0 + 55);
    bus.seq_stop_i = 1'b1;
    next();
    bus.seq_stop_i = 1'b0;
    bus.seq_loop_i = 1'b0;
    drain("loop", 100);

    // Stop in the middle of step 1 hold
    start_seq(4'd3, 1'b0, e0);
    push(e0 + 3,  3'b001, 4'd1, 3'd0, 1'b1, 1'b0, 1'b0);
    push(e0 + 23, 3'b001, 4'd0, 3'd1, 1'b1, 1'b0, 1'b0);
    push(e0 + 25, 3'b010, 4'd2, 3'd1, 1'b1, 1'b0, 1'b0);
    push(e0 + 29, 3'b010, 4'd0, 3'd1, 1'b0, 1'b0, 1'b1);
    step_to(e0 + 28);
    bus.seq_stop_i = 1'b1;
    next();
    bus.seq_stop_i = 1'b0;
    drain("stop", 100);

    // Real-scan preemption; start and table write during REAL must be dropped
    start_seq(4'd3, 1'b0, e0);
    push(e0 + 3,  3'b001, 4'd1, 3'd0, 1'b1, 1'b0, 1'b0);
    push(e0 + 11, 3'b011, 4'd1, 3'd0, 1'b1, 1'b0, 1'b1);
    push(e0 + 23, 3'b011, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    step_to(e0 + 8);
    bus.real_scan_flag_i = 1'b1;
    step_to(e0 + 15);
    start_seq(4'd3, 1'b0, e0);
    e0 = e0 - 15;
    wr(3'd0, 32'h0005_070F);
    step_to(e0 + 20);
    bus.real_scan_flag_i = 1'b0;
    drain("real", 100);

    // Table unchanged by the dropped write
    start_seq(4'd3, 1'b0, e0);
    push_three(e0);
    drain("rerun", 100);

    // Reset during step 1 hold, then a fresh run
    start_seq(4'd3, 1'b0, e0);
    push(e0 + 3,  3'b001, 4'd1, 3'd0, 1'b1, 1'b0, 1'b0);
    push(e0 + 23, 3'b001, 4'd0, 3'd1, 1'b1, 1'b0, 1'b0);
    push(e0 + 25, 3'b010, 4'd2, 3'd1, 1'b1, 1'b0, 1'b0);
    step_to(e0 + 28);
    rst_i = 1'b1;
    next();
    rst_i = 1'b0;
    check("mid_rst_cmd",   {28'd0, bus.pmt_scan_cmd_o},     32'd0);
    check("mid_rst_sel",   {29'd0, bus.pmt_scan_cmd_sel_o}, 32'd0);
    check("mid_rst_busy",  {31'd0, bus.seq_busy_o},         32'd0);
    check("mid_rst_step",  {29'd0, bus.seq_step_o},         32'd0);
    check("mid_rst_done",  {31'd0, bus.seq_done_o},         32'd0);
    check("mid_rst_abort", {31'd0, bus.seq_abort_o},        32'd0);
    drain("mid_rst", 10);

    start_seq(4'd3, 1'b0, e0);
    push_three(e0);
    drain("post_rst", 100);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
